// File: rtl/vp_mem_pkg.sv
// Shared types and constants for the wait-state memory slave and its LFSR.
package vp_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    // Fibonacci taps 16,14,13,11 as a mask over state bits [15:0]
    localparam logic [15:0] LfsrTaps = 16'hB400;
    localparam logic [15:0] DefaultSeed = 16'hACE1;
    localparam int unsigned MaxWaitStates = 15;

endpackage

// File: rtl/vp_wait_mem_if.sv
// VProc-side memory bus between a node and the wait-state memory slave.
interface vp_wait_mem_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [31:0]           Addr;
    logic                  CS;
    logic                  WE;
    logic                  RD;
    logic [DATA_WIDTH-1:0] DI;
    logic [DATA_WIDTH-1:0] DO;
    logic                  WRAck;
    logic                  RDAck;
    logic                  Busy;

    modport master (
        output Addr, CS, WE, RD, DI,
        input  DO, WRAck, RDAck, Busy
    );

    modport slave (
        input  Addr, CS, WE, RD, DI,
        output DO, WRAck, RDAck, Busy
    );
endinterface

// File: rtl/vp_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left every clock, reloads the seed on reset.
module vp_lfsr16 import vp_mem_pkg::*; (
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] seed,
    output logic [15:0] state
);
    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = {state_q[14:0], ^(state_q & LfsrTaps)};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
endmodule

// File: rtl/vp_wait_mem.sv
// Word-addressed RAM slave for a VProc node that inserts wait states before each ack.
// Define VP_RANDOM_WAIT_EN to add 0..3 LFSR-driven extra wait cycles per access.
module vp_wait_mem import vp_mem_pkg::*; #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] LFSR_SEED   = DefaultSeed
) (
    input logic          clk,
    input logic          nreset,
    vp_wait_mem_if.slave bus
);
    localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
    localparam int unsigned WaitCfg = (WAIT_STATES > MaxWaitStates) ? MaxWaitStates : WAIT_STATES;

    logic [DATA_WIDTH-1:0] mem [Depth];

    state_e                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, xfer_addr;
    logic [DATA_WIDTH-1:0] data_q, data_d, xfer_data;
    logic [DATA_WIDTH-1:0] do_q, do_d;
    logic                  dir_q, dir_d, xfer_dir;
    logic                  wrack_q, wrack_d;
    logic                  rdack_q, rdack_d;
    logic                  req;
    logic                  enter_ack;
    logic [1:0]            extra;
    logic [4:0]            wait_load;
    logic                  unused_addr;

`ifdef VP_RANDOM_WAIT_EN
    logic [15:0] lfsr_state;
    logic [13:0] unused_lfsr;

    vp_lfsr16 u_lfsr (
        .clk    (clk),
        .nreset (nreset),
        .seed   (LFSR_SEED),
        .state  (lfsr_state)
    );

    assign extra       = lfsr_state[1:0];
    assign unused_lfsr = lfsr_state[15:2];
`else
    logic unused_seed;

    assign extra       = 2'b00;
    assign unused_seed = ^LFSR_SEED;
`endif

    assign unused_addr = ^bus.Addr[31:ADDR_WIDTH];
    assign req         = bus.CS & (bus.WE | bus.RD);
    assign wait_load   = 5'(WaitCfg) + {3'b000, extra};

    // In IDLE the transfer uses the live bus so a zero-wait access completes on its request edge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        dir_d     = dir_q;
        wrack_d   = 1'b0;
        rdack_d   = 1'b0;
        do_d      = do_q;
        enter_ack = 1'b0;
        xfer_addr = addr_q;
        xfer_data = data_q;
        xfer_dir  = dir_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d    = bus.Addr[ADDR_WIDTH-1:0];
                    data_d    = bus.DI;
                    dir_d     = bus.WE;
                    xfer_addr = bus.Addr[ADDR_WIDTH-1:0];
                    xfer_data = bus.DI;
                    xfer_dir  = bus.WE;
                    if (wait_load == 5'd0) begin
                        state_d   = StAck;
                        enter_ack = 1'b1;
                        cnt_d     = 5'd0;
                    end else begin
                        state_d = StWait;
                        cnt_d   = wait_load;
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 5'd1) begin
                    state_d   = StAck;
                    enter_ack = 1'b1;
                    cnt_d     = 5'd0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (enter_ack) begin
            wrack_d = xfer_dir;
            rdack_d = ~xfer_dir;
            if (!xfer_dir) begin
                do_d = mem[xfer_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            addr_q  <= '0;
            data_q  <= '0;
            dir_q   <= 1'b0;
            wrack_q <= 1'b0;
            rdack_q <= 1'b0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            wrack_q <= wrack_d;
            rdack_q <= rdack_d;
            do_q    <= do_d;
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (enter_ack && xfer_dir) begin
            mem[xfer_addr] <= xfer_data;
        end
    end

    assign bus.DO    = do_q;
    assign bus.WRAck = wrack_q;
    assign bus.RDAck = rdack_q;
    assign bus.Busy  = (state_q != StIdle);
endmodule
